// File: rtl/skinny_sbox_layer_cms1_ctrl.sv
// skinny_sbox_layer_cms1_ctrl
// Drives one shared 2-share CMS1 SKINNY 8-bit S-box over all cells of a
// two-share state, one cell at a time. It takes one fresh random word per
// cell from a valid/ready stream. The S-box inputs stay stable for the whole
// two-cycle evaluation window: the first S-box stage captures on the falling
// edge and the second stage on the rising edge.
// Build option: define SKINNY_SBOX_CTRL_PRECHARGE_EN to always pass through a
// zeroed FETCH cycle between cells instead of running cells back to back.
module skinny_sbox_layer_cms1_ctrl #(
    parameter int NCELLS = 16,
    parameter int RW     = 76
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NCELLS-1:0]   st0_in,
    input  logic [8*NCELLS-1:0]   st1_in,
    output logic                  busy,
    output logic                  done,
    output logic [8*NCELLS-1:0]   st0_out,
    output logic [8*NCELLS-1:0]   st1_out,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    input  logic [RW-1:0]         rnd_data,
    output logic [7:0]            sb_si0,
    output logic [7:0]            sb_si1,
    output logic [RW-1:0]         sb_r,
    input  logic [7:0]            sb_bo0,
    input  logic [7:0]            sb_bo1
);

    localparam int IW = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EVAL1 = 3'd2,
        S_EVAL2 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [IW-1:0]        r_idx;
    logic [8*NCELLS-1:0]  r_work0;
    logic [8*NCELLS-1:0]  r_work1;
    logic [8*NCELLS-1:0]  r_out0;
    logic [8*NCELLS-1:0]  r_out1;
    logic [7:0]           r_sb_si0;
    logic [7:0]           r_sb_si1;
    logic [RW-1:0]        r_sb_r;

    logic                 w_last;
    logic                 w_xfer;
    logic [IW-1:0]        w_sel_idx;
    logic [7:0]           w_cell0 [NCELLS];
    logic [7:0]           w_cell1 [NCELLS];
    logic [8*NCELLS-1:0]  w_upd0;
    logic [8*NCELLS-1:0]  w_upd1;

    assign w_last = (r_idx == LAST_IDX);
    assign w_xfer = rnd_valid & rnd_ready;

    // In EVAL2 the cell to load next is the following one; in FETCH it is the current one.
    assign w_sel_idx = (r_state == S_EVAL2) ? (r_idx + IW'(1)) : r_idx;

    // Per-cell views of the working state, and the working state with the
    // current cell replaced by the S-box result shares (shares stay separate).
    for (genvar gi = 0; gi < NCELLS; gi++) begin : g_cell
        assign w_cell0[gi]         = r_work0[8*gi +: 8];
        assign w_cell1[gi]         = r_work1[8*gi +: 8];
        assign w_upd0[8*gi +: 8]   = (r_idx == IW'(gi)) ? sb_bo0 : r_work0[8*gi +: 8];
        assign w_upd1[8*gi +: 8]   = (r_idx == IW'(gi)) ? sb_bo1 : r_work1[8*gi +: 8];
    end

    assign st0_out = r_out0;
    assign st1_out = r_out1;
    assign sb_si0  = r_sb_si0;
    assign sb_si1  = r_sb_si1;
    assign sb_r    = r_sb_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_FETCH;
            S_FETCH: if (rnd_valid) w_state_next = S_EVAL1;
            S_EVAL1: w_state_next = S_EVAL2;
            S_EVAL2: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else if (w_xfer) begin
                    w_state_next = S_EVAL1;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Status outputs and the randomness handshake.
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        rnd_ready = 1'b0;
        case (r_state)
            S_FETCH: rnd_ready = 1'b1;
`ifdef SKINNY_SBOX_CTRL_PRECHARGE_EN
            S_EVAL2: rnd_ready = 1'b0;
`else
            S_EVAL2: rnd_ready = ~w_last;
`endif
            default: rnd_ready = 1'b0;
        endcase
    end

    // Datapath: working state, cell counter, S-box input registers, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_work0  <= '0;
            r_work1  <= '0;
            r_out0   <= '0;
            r_out1   <= '0;
            r_sb_si0 <= '0;
            r_sb_si1 <= '0;
            r_sb_r   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work0 <= st0_in;
                        r_work1 <= st1_in;
                        r_idx   <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_xfer) begin
                        r_sb_si0 <= w_cell0[w_sel_idx];
                        r_sb_si1 <= w_cell1[w_sel_idx];
                        r_sb_r   <= rnd_data;
                    end
                end
                S_EVAL2: begin
                    r_work0 <= w_upd0;
                    r_work1 <= w_upd1;
                    if (w_last) begin
                        r_out0   <= w_upd0;
                        r_out1   <= w_upd1;
                        r_sb_si0 <= '0;
                        r_sb_si1 <= '0;
                        r_sb_r   <= '0;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                        if (w_xfer) begin
                            r_sb_si0 <= w_cell0[w_sel_idx];
                            r_sb_si1 <= w_cell1[w_sel_idx];
                            r_sb_r   <= rnd_data;
                        end else begin
                            r_sb_si0 <= '0;
                            r_sb_si1 <= '0;
                            r_sb_r   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_skinny_sbox_layer_cms1_ctrl.sv
// tb_skinny_sbox_layer_cms1_ctrl
// Bench for the serial CMS1 SKINNY S-box layer sequencer. It contains a
// timing-faithful S-box stand-in: the falling-edge stage and the rising-edge
// stage, with output shares that depend combinationally on the input shares.
// It also contains a per-cycle reference monitor and directed layers.
// Build option honoured: SKINNY_SBOX_CTRL_PRECHARGE_EN.
`timescale 1ns/1ps
module tb_skinny_sbox_layer_cms1_ctrl;
    localparam int NCELLS = 16;
    localparam int RW     = 76;
    localparam int SW     = 8 * NCELLS;
`ifdef SKINNY_SBOX_CTRL_PRECHARGE_EN
    localparam bit PRE      = 1'b1;
    localparam int BASE_LAT = 48;
`else
    localparam bit PRE      = 1'b0;
    localparam int BASE_LAT = 33;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] st0_in = '0;
    logic [SW-1:0] st1_in = '0;
    logic          busy, done;
    logic [SW-1:0] st0_out, st1_out;
    logic          rnd_valid = 1'b0;
    logic          rnd_ready;
    logic [RW-1:0] rnd_data = '0;
    logic [7:0]    sb_si0, sb_si1;
    logic [RW-1:0] sb_r;
    logic [7:0]    sb_bo0, sb_bo1;

    int nvec = 0;
    int nmis = 0;
    int unsigned ecnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    skinny_sbox_layer_cms1_ctrl #(.NCELLS(NCELLS), .RW(RW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .st0_in(st0_in), .st1_in(st1_in),
        .busy(busy), .done(done),
        .st0_out(st0_out), .st1_out(st1_out),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .sb_si0(sb_si0), .sb_si1(sb_si1), .sb_r(sb_r),
        .sb_bo0(sb_bo0), .sb_bo1(sb_bo1)
    );

    // SKINNY 8-bit S-box from its mix/permute round description.
    function automatic logic [7:0] sbox8(input logic [7:0] a);
        logic [7:0] x;
        x = a;
        for (int i = 0; i < 4; i++) begin
            x = x ^ (~(((x >> 1) | x) >> 2) & 8'h11);
            if (i < 3)
                x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5)
                  | ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
        end
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    // S-box stand-in: stage 1 on the falling edge, stage 2 on the rising edge.
    logic [7:0] m1 = '0, r1 = '0, s2 = '0, mask2 = '0;
    always @(negedge clk) begin
        m1 <= sb_si0 ^ sb_si1;
        r1 <= sb_r[7:0];
    end
    always @(posedge clk) begin
        s2    <= sbox8(m1);
        mask2 <= r1;
    end
    assign sb_bo0 = s2 ^ mask2 ^ sb_si0;
    assign sb_bo1 = mask2 ^ sb_si0;

    task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model state.
    logic [SW-1:0] lat0 = '0, lat1 = '0, held0 = '0, held1 = '0, ex0, ex1;
    logic [RW-1:0] words [NCELLS];
    logic [RW-1:0] cur_word = '0;
    int nxfer = 0, since = 99, stall_left = 0, nlayer = 0;
    int stall_tab [NCELLS];
    bit lay = 1'b0, xfer_pend = 1'b0, clr_pend = 1'b0, need_new = 1'b1;

    // Compare process and randomness source, once per cycle on the falling edge.
    always @(negedge clk) begin
        bit exp_done, exp_rdy;
        int k;
        logic [95:0] tmp;
        logic [7:0] c0, c1;
        if (rst) begin
            lay = 0; xfer_pend = 0; clr_pend = 0; nxfer = 0; since = 99;
            stall_left = 0; held0 = '0; held1 = '0;
        end else begin
            if (clr_pend) begin lay = 0; clr_pend = 0; end
            if (xfer_pend) begin since = 1; xfer_pend = 0; end
            else if (since < 99) since++;
            if (!lay && start) begin
                lay = 1; lat0 = st0_in; lat1 = st1_in; nxfer = 0; since = 99;
                stall_left = stall_tab[0];
            end
        end
        exp_done = lay && (since == 3) && (nxfer == NCELLS);
        if (!lay || since == 1)  exp_rdy = 1'b0;
        else if (since == 2)     exp_rdy = (nxfer < NCELLS) && !PRE;
        else                     exp_rdy = (nxfer < NCELLS);
        chk("busy", busy, lay);
        chk("done", done, exp_done);
        chk("rnd_ready", rnd_ready, exp_rdy);
        if (lay && (since == 1 || since == 2)) begin
            k = (nxfer > 0 && nxfer <= NCELLS) ? nxfer - 1 : 0;
            chk("sb_si0_hold", sb_si0, lat0[8*k +: 8]);
            chk("sb_si1_hold", sb_si1, lat1[8*k +: 8]);
            chk("sb_r_hold", sb_r, words[k]);
        end else if (lay && nxfer < NCELLS) begin
            chk("sb_si0_fetch_zero", sb_si0, '0);
            chk("sb_si1_fetch_zero", sb_si1, '0);
            chk("sb_r_fetch_zero", sb_r, '0);
        end
        if (exp_done) begin
            for (int c = 0; c < NCELLS; c++) begin
                c0 = lat0[8*c +: 8];
                c1 = lat1[8*c +: 8];
                ex1[8*c +: 8] = words[c][7:0] ^ c0;
                ex0[8*c +: 8] = words[c][7:0] ^ c0 ^ sbox8(c0 ^ c1);
            end
            held0 = ex0; held1 = ex1; clr_pend = 1;
            nlayer++;
            $display("layer %0d: st0_out=%h st1_out=%h", nlayer, ex0, ex1);
        end
        chk("st0_out", st0_out, held0);
        chk("st1_out", st1_out, held1);
        // Drive the random stream for the coming cycle.
        if (need_new) begin
            tmp = {$urandom(), $urandom(), $urandom()};
            cur_word = tmp[RW-1:0];
            need_new = 0;
        end
        rnd_data = cur_word;
        if (lay && rnd_ready && stall_left > 0) begin
            rnd_valid = 1'b0;
            stall_left--;
        end else begin
            rnd_valid = 1'b1;
        end
        if (!rst && rnd_valid && rnd_ready) begin
            if (nxfer < NCELLS) words[nxfer] = cur_word;
            nxfer++;
            xfer_pend = 1; need_new = 1;
            if (nxfer < NCELLS) stall_left = stall_tab[nxfer];
        end
    end

    task automatic launch(input logic [SW-1:0] a0, input logic [SW-1:0] a1,
                          input int s0, input int s7, output int t0);
        for (int i = 0; i < NCELLS; i++) stall_tab[i] = 0;
        stall_tab[0] = s0;
        stall_tab[7] = s7;
        @(negedge clk); #2;
        st0_in = a0; st1_in = a1; start = 1'b1;
        t0 = int'(ecnt) + 1;
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat);
        bit got;
        got = 0; lat = -1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk); #1;
            if (done) begin got = 1; lat = int'(ecnt) - t0; end
        end
        nvec++;
        if (!got) begin
            nmis++;
            $display("FAIL done_timeout: no done within 300 cycles, required one");
        end
        $display("layer latency %0d edges", lat);
    endtask

    task automatic run_layer(input logic [SW-1:0] a0, input logic [SW-1:0] a1,
                             input int s0, input int s7, output int lat);
        int t0;
        launch(a0, a1, s0, s7, t0);
        wait_done(t0, lat);
    endtask

    initial begin
        logic [SW-1:0] r, pat, x, xb;
        int lat, t0, extra;
        bit found;
        for (int i = 0; i < NCELLS; i++) begin
            stall_tab[i] = 0;
            pat[8*i +: 8] = 8'(i);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy, '0);
        chk("reset_st0_out", st0_out, '0);
        chk("reset_sb_r", sb_r, '0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // All-zero shares: every cell unmasks to S(0) = 0x65.
        run_layer('0, '0, 0, 0, lat);
        chk("A_latency", lat, BASE_LAT);
        chk("A_xfers", nxfer, NCELLS);
        x = st0_out ^ st1_out;
        for (int k = 0; k < NCELLS; k++) chk("A_cell", x[8*k +: 8], 8'h65);

        // Random masking of 0xFF: every cell unmasks to S(0xFF) = 0xFF.
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_layer(r, r ^ {NCELLS{8'hFF}}, 0, 0, lat);
        chk("B_latency", lat, BASE_LAT);
        chk("B_xfers", nxfer, NCELLS);
        xb = st0_out ^ st1_out;
        for (int k = 0; k < NCELLS; k++) chk("B_cell", xb[8*k +: 8], 8'hFF);

        // Same state with stalls before cells 0 and 7.
        run_layer(r, r ^ {NCELLS{8'hFF}}, 5, 3, lat);
        chk("C_latency", lat, BASE_LAT + 8);
        chk("C_xfers", nxfer, NCELLS);
        chk("C_result", st0_out ^ st1_out, xb);

        // start pulsed mid-layer with different inputs must be ignored.
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        launch(r, r ^ pat, 0, 0, t0);
        repeat (8) @(negedge clk);
        #2 st0_in = ~r; start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
        wait_done(t0, lat);
        chk("D_latency", lat, BASE_LAT);
        x = st0_out ^ st1_out;
        for (int k = 0; k < NCELLS; k++) chk("D_cell", x[8*k +: 8], sbox8(8'(k)));
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (done) extra++;
        end
        chk("D_single_done", extra, 0);

        // Reset during EVAL1 of cell 4, then a clean ordering run.
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        launch(r, r ^ pat, 0, 0, t0);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk); #1;
            if (lay && nxfer == 5 && since == 1) found = 1;
        end
        chk("E_reached_cell4", found, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("E_rst_busy", busy, '0);
        chk("E_rst_done", done, '0);
        chk("E_rst_ready", rnd_ready, '0);
        chk("E_rst_sb", {sb_si0, sb_si1, sb_r}, '0);
        chk("E_rst_st0_out", st0_out, '0);
        chk("E_rst_st1_out", st1_out, '0);
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        run_layer(r, r ^ pat, 0, 0, lat);
        chk("E_latency", lat, BASE_LAT);
        x = st0_out ^ st1_out;
        chk("E_cell0", x[7:0], 8'h65);
        chk("E_cell1", x[15:8], 8'h4C);
        for (int k = 0; k < NCELLS; k++) chk("E_cell", x[8*k +: 8], sbox8(8'(k)));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
